// File: rtl/speed_pwm_gen_if.sv
// -----------------------------------------------------------------------------
// speed_pwm_gen_if
//   Duty-write bus for the speed-class PWM generator. The controller side
//   (master) posts one-cycle write strobes carrying a channel select and a
//   new duty value; the generator side (slave) answers with a one-cycle
//   error pulse when the select does not name a channel.
//
// Signals
//   dutyWe   master -> slave  duty write strobe, one cycle per write
//   dutySel  master -> slave  channel select (0 veer .. 4 ninetyFast)
//   dutyVal  master -> slave  new duty in clk cycles, CNT_W bits
//   dutyErr  slave  -> master one-cycle pulse after a write to an illegal channel
// -----------------------------------------------------------------------------
interface speed_pwm_gen_if #(
  parameter int CNT_W = 16
);

  logic             dutyWe;
  logic [2:0]       dutySel;
  logic [CNT_W-1:0] dutyVal;
  logic             dutyErr;

  modport master (
    output dutyWe,
    output dutySel,
    output dutyVal,
    input  dutyErr
  );

  modport slave (
    input  dutyWe,
    input  dutySel,
    input  dutyVal,
    output dutyErr
  );

endinterface

// File: rtl/speed_pwm_gen.sv
// -----------------------------------------------------------------------------
// speed_pwm_gen
//   Five phase-aligned PWM channels (veer, full, hard, ninety, ninetyFast)
//   driven from one shared period counter. Every channel owns a shadow and an
//   active duty register; writes land in the shadow and are copied to the
//   active register only at a period boundary, so a waveform never changes
//   shape in the middle of a period. After enable, a soft-start ramp caps
//   every duty and grows by RAMP_STEP each period until it reaches PERIOD.
//
// Parameters
//   PERIOD     period length in clk cycles (2 .. 2^CNT_W-1)
//   CNT_W      width of the counter and of the duty values
//   RAMP_STEP  ramp increment per period; 0 turns the ramp off
//   DUTY0..4   duty loaded into shadow and active registers by reset
//
// Ports
//   clk                 system clock
//   rst                 asynchronous reset, active low
//   en                  run enable; low returns to IDLE with all outputs low
//   duty_bus            duty write bus (slave side), see speed_pwm_gen_if
//   veerSpeedPwm ..
//   ninetyFastSpeedPwm  registered PWM outputs, channels 0..4
//   periodStart         one-cycle pulse in the first cycle of each period
// -----------------------------------------------------------------------------
module speed_pwm_gen #(
  parameter int PERIOD    = 25000,
  parameter int CNT_W     = 16,
  parameter int RAMP_STEP = 2500,
  parameter int DUTY0     = 12500,
  parameter int DUTY1     = 25000,
  parameter int DUTY2     = 18750,
  parameter int DUTY3     = 10000,
  parameter int DUTY4     = 15000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  speed_pwm_gen_if.slave  duty_bus,
  output logic            veerSpeedPwm,
  output logic            fullSpeedPwm,
  output logic            hardSpeedPwm,
  output logic            ninetySpeedPwm,
  output logic            ninetyFastSpeedPwm,
  output logic            periodStart
);

  localparam int               NUM_CH      = 5;
  localparam logic [CNT_W-1:0] PERIOD_V    = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] STEP_V      = CNT_W'(RAMP_STEP);
  localparam bit               RAMP_ON     = (RAMP_STEP != 0);

  typedef enum logic [1:0] {
    IDLE,
    SOFT,
    RUN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ramp;
  logic [CNT_W-1:0] shadow [NUM_CH];
  logic [CNT_W-1:0] active [NUM_CH];
  logic [NUM_CH-1:0] pwm;
  logic             period_start;
  logic             duty_err;

  logic             wr_ok;
  logic             wr_bad;
  logic             at_last;
  logic             load_active;
  logic [CNT_W:0]   ramp_sum;
  logic             ramp_done;
  logic [CNT_W-1:0] ramp_next;
  logic [CNT_W-1:0] shadow_next [NUM_CH];
  logic [CNT_W-1:0] eff [NUM_CH];
  logic [NUM_CH-1:0] hit;

  // Reset duty for a channel, taken from the DUTYn parameters.
  function automatic logic [CNT_W-1:0] reset_duty(input int ch);
    case (ch)
      0:       return CNT_W'(DUTY0);
      1:       return CNT_W'(DUTY1);
      2:       return CNT_W'(DUTY2);
      3:       return CNT_W'(DUTY3);
      default: return CNT_W'(DUTY4);
    endcase
  endfunction

  // Decode the write bus and the period boundary. The active registers load
  // from shadow_next rather than shadow so that a write arriving on the wrap
  // cycle (or on the enabling cycle) goes straight through to the period
  // that starts at that edge.
  always_comb begin
    wr_ok       = duty_bus.dutyWe && (duty_bus.dutySel < 3'd5);
    wr_bad      = duty_bus.dutyWe && (duty_bus.dutySel >= 3'd5);
    at_last     = (cnt == PERIOD_LAST);
    load_active = en && ((state == IDLE) || at_last);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      shadow_next[ch] = (wr_ok && (duty_bus.dutySel == 3'(ch)))
                        ? duty_bus.dutyVal : shadow[ch];
    end
  end

  // Ramp arithmetic is done one bit wider than the counter so that
  // ramp + RAMP_STEP cannot wrap around before it is clamped to PERIOD.
  always_comb begin
    ramp_sum  = {1'b0, ramp} + {1'b0, STEP_V};
    ramp_done = (ramp_sum >= {1'b0, PERIOD_V});
    ramp_next = ramp_done ? PERIOD_V : ramp_sum[CNT_W-1:0];
  end

  // Effective duty and compare. During soft start the ramp caps the duty;
  // with the ramp switched off the active duty is used from the first period.
  // Duties at or above PERIOD need no special case: cnt never reaches them.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      eff[ch] = active[ch];
      if ((state == SOFT) && RAMP_ON && (ramp < active[ch])) begin
        eff[ch] = ramp;
      end
      hit[ch] = (state != IDLE) && (cnt < eff[ch]);
    end
  end

  // Main state machine. Outputs are registered from the current cnt, so each
  // PWM edge trails the counter by one cycle and periodStart fires in the
  // cycle after cnt returns to 0. Shadow and active duties survive a drop to
  // IDLE and are only restored to DUTYn by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ramp         <= '0;
      pwm          <= '0;
      period_start <= 1'b0;
      duty_err     <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        shadow[ch] <= reset_duty(ch);
        active[ch] <= reset_duty(ch);
      end
    end else begin
      pwm          <= hit;
      period_start <= (state != IDLE) && (cnt == '0);
      duty_err     <= wr_bad;

      for (int ch = 0; ch < NUM_CH; ch++) begin
        shadow[ch] <= shadow_next[ch];
        if (load_active) begin
          active[ch] <= shadow_next[ch];
        end
      end

      case (state)
        IDLE: begin
          cnt  <= '0;
          ramp <= '0;
          if (en) begin
            state <= SOFT;
          end
        end

        SOFT: begin
          if (!en) begin
            state <= IDLE;
            cnt   <= '0;
            ramp  <= '0;
          end else if (at_last) begin
            cnt  <= '0;
            ramp <= ramp_next;
            if (!RAMP_ON || ramp_done) begin
              state <= RUN;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RUN: begin
          if (!en) begin
            state <= IDLE;
            cnt   <= '0;
            ramp  <= '0;
          end else if (at_last) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          ramp  <= '0;
        end
      endcase
    end
  end

  assign veerSpeedPwm       = pwm[0];
  assign fullSpeedPwm       = pwm[1];
  assign hardSpeedPwm       = pwm[2];
  assign ninetySpeedPwm     = pwm[3];
  assign ninetyFastSpeedPwm = pwm[4];
  assign periodStart        = period_start;
  assign duty_bus.dutyErr   = duty_err;

endmodule

// File: tb/tb_speed_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_speed_pwm_gen
//   Two generators share one stimulus stream: dut_a runs with the ramp off,
//   dut_b with RAMP_STEP = 3. A period-level model (position in period,
//   periods since enable, shadow/active duties) predicts every output on
//   every cycle; directed scenarios add hand-computed high-cycle counts.
// -----------------------------------------------------------------------------
module tb_speed_pwm_gen;

  localparam int PERIOD = 10;
  localparam int CNT_W  = 8;

  typedef struct {
    int k;
    int sel;
    int val;
  } wr_t;

  logic             clk;
  logic             rst;
  logic             en;
  logic             we;
  logic [2:0]       sel;
  logic [CNT_W-1:0] val;
  logic [4:0]       pwm_a;
  logic [4:0]       pwm_b;
  logic             ps_a;
  logic             ps_b;

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  speed_pwm_gen_if #(.CNT_W(CNT_W)) bus_a ();
  speed_pwm_gen_if #(.CNT_W(CNT_W)) bus_b ();

  assign bus_a.dutyWe  = we;
  assign bus_a.dutySel = sel;
  assign bus_a.dutyVal = val;
  assign bus_b.dutyWe  = we;
  assign bus_b.dutySel = sel;
  assign bus_b.dutyVal = val;

  speed_pwm_gen #(
    .PERIOD(PERIOD), .CNT_W(CNT_W), .RAMP_STEP(0),
    .DUTY0(5), .DUTY1(2), .DUTY2(6), .DUTY3(8), .DUTY4(9)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .duty_bus(bus_a),
    .veerSpeedPwm(pwm_a[0]), .fullSpeedPwm(pwm_a[1]), .hardSpeedPwm(pwm_a[2]),
    .ninetySpeedPwm(pwm_a[3]), .ninetyFastSpeedPwm(pwm_a[4]),
    .periodStart(ps_a)
  );

  speed_pwm_gen #(
    .PERIOD(PERIOD), .CNT_W(CNT_W), .RAMP_STEP(3),
    .DUTY0(5), .DUTY1(10), .DUTY2(4), .DUTY3(8), .DUTY4(2)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .duty_bus(bus_b),
    .veerSpeedPwm(pwm_b[0]), .fullSpeedPwm(pwm_b[1]), .hardSpeedPwm(pwm_b[2]),
    .ninetySpeedPwm(pwm_b[3]), .ninetyFastSpeedPwm(pwm_b[4]),
    .periodStart(ps_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, one slot per DUT.
  int rst_duty [2][5] = '{'{5, 2, 6, 8, 9}, '{5, 10, 4, 8, 2}};
  int step     [2]    = '{0, 3};
  bit m_run    [2]    = '{0, 0};
  int m_pos    [2]    = '{0, 0};
  int m_k      [2]    = '{0, 0};
  int m_act    [2][5] = '{'{5, 2, 6, 8, 9}, '{5, 10, 4, 8, 2}};
  int m_shd    [2][5] = '{'{5, 2, 6, 8, 9}, '{5, 10, 4, 8, 2}};
  int nxt_shd  [5];
  bit exp_pwm  [2][5];
  bit exp_ps   [2];
  bit exp_err  [2];
  int hi       [2][5];
  wr_t sched[$];

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [4:0] pwm_of(input int d);
    return (d == 0) ? pwm_a : pwm_b;
  endfunction

  function automatic logic ps_of(input int d);
    return (d == 0) ? ps_a : ps_b;
  endfunction

  function automatic logic err_of(input int d);
    return (d == 0) ? bus_a.dutyErr : bus_b.dutyErr;
  endfunction

  // Period-level model: the output of a cycle is "position in period below
  // the duty", where the duty seen in the k-th period after enable is the
  // active duty capped at k * RAMP_STEP when the ramp is on.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        m_run[d] = 0; m_pos[d] = 0; m_k[d] = 0;
        exp_ps[d] = 0; exp_err[d] = 0;
        for (int ch = 0; ch < 5; ch++) begin
          m_act[d][ch] = rst_duty[d][ch];
          m_shd[d][ch] = rst_duty[d][ch];
          exp_pwm[d][ch] = 0;
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int ch = 0; ch < 5; ch++) begin
          int lim;
          lim = (step[d] == 0) ? m_act[d][ch] : min_int(m_act[d][ch], m_k[d] * step[d]);
          exp_pwm[d][ch] = m_run[d] && (m_pos[d] < lim);
          nxt_shd[ch] = (we && int'(sel) == ch) ? int'(val) : m_shd[d][ch];
        end
        exp_ps[d]  = m_run[d] && (m_pos[d] == 0);
        exp_err[d] = we && (sel > 3'd4);
        if (!en) begin
          m_run[d] = 0; m_pos[d] = 0; m_k[d] = 0;
        end else if (!m_run[d] || m_pos[d] == PERIOD - 1) begin
          m_k[d] = !m_run[d] ? 0 : ((m_k[d] < PERIOD) ? m_k[d] + 1 : m_k[d]);
          m_run[d] = 1; m_pos[d] = 0;
          for (int ch = 0; ch < 5; ch++) m_act[d][ch] = nxt_shd[ch];
        end else begin
          m_pos[d] = m_pos[d] + 1;
        end
        for (int ch = 0; ch < 5; ch++) m_shd[d][ch] = nxt_shd[ch];
      end
    end
  end

  task automatic cmp(input string name, input int d, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d @%0t: got %0d expected %0d", name, d, $time, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input int got, input int exp);
    cmp(name, 0, got, exp);
  endtask

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        for (int ch = 0; ch < 5; ch++) begin
          cmp($sformatf("model_pwm%0d", ch), d, int'(pwm_of(d)[ch]), int'(exp_pwm[d][ch]));
        end
        cmp("model_periodStart", d, int'(ps_of(d)), int'(exp_ps[d]));
        cmp("model_dutyErr", d, int'(err_of(d)), int'(exp_err[d]));
      end
    end
  end

  // Wait (bounded) until a negedge where dut_a shows periodStart.
  task automatic waitPeriodStart();
    int n;
    n = 0;
    while (!ps_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("periodStart_timeout", int'(ps_a), 1);
  endtask

  // Called on a periodStart negedge; counts high cycles per channel over one
  // period while issuing the writes queued in sched (k = offset in period,
  // a write at offset k is sampled while cnt = k+1, k = 8 is the wrap cycle).
  task automatic applyStimulus();
    for (int d = 0; d < 2; d++) for (int ch = 0; ch < 5; ch++) hi[d][ch] = 0;
    for (int k = 0; k < PERIOD; k++) begin
      for (int d = 0; d < 2; d++)
        for (int ch = 0; ch < 5; ch++) hi[d][ch] += int'(pwm_of(d)[ch]);
      we = 1'b0;
      foreach (sched[i]) begin
        if (sched[i].k == k) begin
          we  = 1'b1;
          sel = 3'(sched[i].sel);
          val = CNT_W'(sched[i].val);
        end
      end
      @(negedge clk);
    end
    we = 1'b0;
    sched.delete();
  endtask

  task automatic checkCountsA(input string name, input int e0, input int e1,
                              input int e2, input int e3, input int e4);
    int e [5];
    e = '{e0, e1, e2, e3, e4};
    for (int ch = 0; ch < 5; ch++) cmp($sformatf("%s_ch%0d", name, ch), 0, hi[0][ch], e[ch]);
  endtask

  initial begin
    int ramp_exp [6];
    int low_cnt;
    ramp_exp = '{0, 3, 6, 9, 10, 10};
    rst = 1'b0; en = 1'b0; we = 1'b0; sel = '0; val = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    checkOutput("reset_pwm", int'(pwm_a), 0);
    checkOutput("reset_periodStart", int'(ps_a), 0);

    // Enable: first period starts one cycle after en is sampled.
    en = 1'b1;
    @(negedge clk);
    checkOutput("first_ps_not_yet", int'(ps_a), 0);
    @(negedge clk);
    checkOutput("first_ps", int'(ps_a), 1);
    checkOutput("first_veer_high", int'(pwm_a[0]), 1);

    // Reset duties and soft-start ramp over six periods.
    for (int p = 0; p < 6; p++) begin
      applyStimulus();
      cmp($sformatf("veer_high_p%0d", p), 0, hi[0][0], 5);
      cmp($sformatf("ramp_full_p%0d", p), 1, hi[1][1], ramp_exp[p]);
    end

    // Two writes to channel 1 in one period: the last one wins next period.
    sched.push_back('{3, 1, 3});
    sched.push_back('{5, 1, 7});
    applyStimulus();
    checkOutput("full_unchanged", hi[0][1], 2);
    applyStimulus();
    checkOutput("full_last_wins", hi[0][1], 7);

    // Boundary duties: 0 is constant low, PERIOD and above constant high.
    sched.push_back('{2, 2, 0});
    sched.push_back('{3, 3, 10});
    sched.push_back('{4, 4, 15});
    applyStimulus();
    checkCountsA("pre_boundary", 5, 7, 6, 8, 9);
    applyStimulus();
    checkCountsA("boundary", 5, 7, 0, 10, 10);
    cmp("boundary_b_ninetyFast", 1, hi[1][4], 10);

    // Write on the wrap cycle applies at once; one on cnt=0 waits a period.
    sched.push_back('{8, 0, 3});
    applyStimulus();
    checkOutput("wrap_write_cur", hi[0][0], 5);
    sched.push_back('{9, 0, 5});
    applyStimulus();
    checkOutput("wrap_write_through", hi[0][0], 3);
    applyStimulus();
    checkOutput("cnt0_write_delayed", hi[0][0], 3);
    applyStimulus();
    checkOutput("cnt0_write_applied", hi[0][0], 5);

    // Drop en while outputs are high, then re-enable: duties retained.
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("en_low_pwm_a", int'(pwm_a), 0);
    cmp("en_low_pwm_b", 1, int'(pwm_b), 0);
    repeat (2) @(negedge clk);
    en = 1'b1;
    waitPeriodStart();
    applyStimulus();
    checkCountsA("reenable", 5, 7, 0, 10, 10);

    // Illegal channel select: error pulse, no duty change.
    we = 1'b1; sel = 3'd6; val = CNT_W'(1);
    @(negedge clk);
    we = 1'b0;
    checkOutput("dutyErr_pulse", int'(bus_a.dutyErr), 1);
    @(negedge clk);
    checkOutput("dutyErr_clear", int'(bus_a.dutyErr), 0);
    waitPeriodStart();
    applyStimulus();
    checkCountsA("after_illegal", 5, 7, 0, 10, 10);

    // Randomized writes and enable drops, checked by the model every cycle.
    low_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      we  = ($urandom_range(0, 3) == 0);
      sel = 3'($urandom_range(0, 7));
      val = CNT_W'($urandom_range(0, 14));
      if (low_cnt > 0) begin
        low_cnt--;
        if (low_cnt == 0) en = 1'b1;
      end else if ($urandom_range(0, 99) == 0) begin
        en = 1'b0;
        low_cnt = $urandom_range(1, 3);
      end
      @(negedge clk);
    end
    we = 1'b0;
    en = 1'b1;

    // Asynchronous reset mid-period restores the DUTYn values.
    waitPeriodStart();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_pwm_a", int'(pwm_a), 0);
    cmp("async_rst_pwm_b", 1, int'(pwm_b), 0);
    checkOutput("async_rst_ps", int'(ps_a), 0);
    @(negedge clk);
    rst = 1'b1;
    waitPeriodStart();
    applyStimulus();
    checkCountsA("post_reset", 5, 2, 6, 8, 9);
    cmp("post_reset_ramp_full", 1, hi[1][1], 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
